// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Read-side companion to the synchronous FIFO. It drains a non-FWFT FIFO
//   read port and turns the entries into a valid/ready stream. Reads are
//   prefetched into a small circular buffer, which hides the FIFO read
//   latency and keeps the stream at one beat per cycle. A read is only
//   issued when a buffer slot is guaranteed for its data.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fifo_empty       source FIFO empty flag
//   fifo_rd_en       read request to the source FIFO
//   fifo_dout        source FIFO read data
//   fifo_valid       fifo_dout valid, RD_LATENCY cycles after a read
//   m_valid/m_ready  stream handshake
//   m_data           stream data (buffer head)
//   flush            synchronous discard of buffered and in-flight data
//   occupancy        entries currently held in the local buffer
//   err_unexp_valid  sticky: fifo_valid arrived with no read outstanding
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_valid,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  input  logic                             flush,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy,
  output logic                             err_unexp_valid
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int INF_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] buffer [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [OCC_W-1:0]      occ;
  logic [INF_W-1:0]      inflight;
  logic [INF_W-1:0]      discard;

  logic                  pop;
  logic                  capture;
  logic                  live_valid;
  logic                  unexp;
  logic [INF_W-1:0]      pending;
  logic [INF_W-1:0]      discard_load;
  int                    space;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid   = (occ != '0);
  assign m_data    = buffer[head];
  assign occupancy = occ;

  // Read issue and data classification. A slot freed by this cycle's pop
  // counts as space, which is what lets the stream run at one beat/cycle.
  // rd_en is gated by rst_n so no read leaks out while the block is held
  // in reset with a non-empty source.
  always_comb begin
    pop          = m_valid && m_ready;
    space        = BUF_DEPTH - int'(occ) - int'(inflight) + (pop ? 1 : 0);
    fifo_rd_en   = rst_n && !fifo_empty && (space >= 1) && !flush && (discard == '0);
    // Returns drain the discard count first: those reads were issued
    // before any read that is still counted in inflight.
    live_valid   = fifo_valid && (discard == '0) && (inflight != '0);
    capture      = live_valid && !flush;
    unexp        = fifo_valid && (inflight == '0) && (discard == '0);
    pending      = discard + inflight;
    discard_load = (fifo_valid && (pending != '0)) ? pending - 1'b1 : pending;
  end

  // Buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= '0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (capture) begin
        buffer[tail] <= fifo_dout;
        tail         <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({capture, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Outstanding-read bookkeeping. On flush every read still owed by the
  // FIFO moves into discard, less the one returning in the flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      discard  <= '0;
    end else if (flush) begin
      inflight <= '0;
      discard  <= discard_load;
    end else begin
      if ((discard != '0) && fifo_valid) discard <= discard - 1'b1;
      case ({fifo_rd_en, live_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err_unexp_valid <= 1'b0;
    else if (unexp) err_unexp_valid <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain. dut1 (RD_LATENCY=1, BUF_DEPTH=2) is fed by a
// behavioural source FIFO; dut2 (RD_LATENCY=2, BUF_DEPTH=3) is driven from
// a table of hand-computed per-cycle vectors around a flush.
module tb_fifo_stream_drain;

  logic clk;
  logic rst_n;
  logic rst2_n;

  // dut1 signals
  logic       fifo_empty1, fifo_rd_en1, fifo_valid1;
  logic [7:0] fifo_dout1;
  logic       m_valid1, m_ready1, flush1, err1;
  logic [7:0] m_data1;
  logic [1:0] occupancy1;

  // dut2 signals
  logic       fifo_empty2, fifo_rd_en2, fifo_valid2;
  logic [7:0] fifo_dout2;
  logic       m_valid2, m_ready2, flush2, err2;
  logic [7:0] m_data2;
  logic [1:0] occupancy2;

  int tests;
  int fails;

  fifo_stream_drain #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
    .fifo_dout(fifo_dout1), .fifo_valid(fifo_valid1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .flush(flush1), .occupancy(occupancy1), .err_unexp_valid(err1)
  );

  fifo_stream_drain #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
    .fifo_dout(fifo_dout2), .fifo_valid(fifo_valid2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .flush(flush2), .occupancy(occupancy2), .err_unexp_valid(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural source FIFO for dut1, read latency 1, reset with the drain.
  logic [7:0] mem [0:63];
  int         wr_ptr;
  int         rd_ptr;
  logic       model_valid;
  logic [7:0] model_dout;
  logic       inj_valid;

  assign fifo_empty1 = (wr_ptr == rd_ptr);
  assign fifo_valid1 = model_valid | inj_valid;
  assign fifo_dout1  = model_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= 0;
      model_valid <= 1'b0;
      model_dout  <= 8'h00;
    end else begin
      model_valid <= 1'b0;
      if (fifo_rd_en1 && !fifo_empty1) begin
        model_dout  <= mem[rd_ptr];
        model_valid <= 1'b1;
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  task automatic loadWord(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       empty;
    logic       valid;
    logic [7:0] dout;
    logic       ready;
    logic       flush;
    logic       exp_rd;
    logic       exp_mv;
    logic [7:0] exp_md;
    logic       chk_md;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t vecs [11];

  task automatic applyStimulus(input vec_t v);
    fifo_empty2 = v.empty;
    fifo_valid2 = v.valid;
    fifo_dout2  = v.dout;
    m_ready2    = v.ready;
    flush2      = v.flush;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  int first_rd, first_mv, last_mv, nexp, max_occ, reads, beats, first_b, last_b;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    wr_ptr = 0;
    inj_valid = 1'b0;
    m_ready1 = 1'b1;
    flush1 = 1'b0;
    fifo_empty2 = 1'b1;
    fifo_valid2 = 1'b0;
    fifo_dout2 = 8'h00;
    m_ready2 = 1'b0;
    flush2 = 1'b0;

    //            empty valid dout   ready flush  rd  mv  md    chk occ
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2};
    vecs[5]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};

    for (int i = 1; i <= 16; i++) loadWord(8'(i));

    // Reset state, held in reset with a non-empty source.
    @(negedge clk);
    #1;
    checkOutput("reset_rd_en", fifo_rd_en1, 0);
    checkOutput("reset_m_valid", m_valid1, 0);
    checkOutput("reset_m_data", m_data1, 0);
    checkOutput("reset_occupancy", occupancy1, 0);
    checkOutput("reset_err", err1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 0x01..0x10 with m_ready=1.
    first_rd = -1; first_mv = -1; last_mv = -1; nexp = 1; max_occ = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (fifo_rd_en1 && first_rd < 0) first_rd = k;
      if (m_valid1) begin
        if (first_mv < 0) first_mv = k;
        checkOutput($sformatf("stream_data_%0d", nexp), m_data1, nexp);
        nexp++;
        last_mv = k;
      end
      if (int'(occupancy1) > max_occ) max_occ = int'(occupancy1);
      @(negedge clk);
    end
    checkOutput("stream_beats", nexp - 1, 16);
    checkOutput("stream_latency", first_mv - first_rd, 2);
    checkOutput("stream_contiguous", last_mv - first_mv, 15);
    checkOutput("stream_occ_bound", (max_occ <= 2), 1);

    // Backpressure: m_ready low, six words waiting.
    m_ready1 = 1'b0;
    for (int i = 0; i < 6; i++) loadWord(8'(8'h21 + i));
    reads = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (fifo_rd_en1) reads++;
      @(negedge clk);
    end
    #1;
    checkOutput("bp_reads", reads, 2);
    checkOutput("bp_rd_en_low", fifo_rd_en1, 0);
    checkOutput("bp_held_data", m_data1, 8'h21);
    checkOutput("bp_occupancy", occupancy1, 2);
    @(negedge clk);
    m_ready1 = 1'b1;
    beats = 0; first_b = -1; last_b = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (m_valid1) begin
        if (first_b < 0) first_b = k;
        checkOutput($sformatf("bp_data_%0d", beats), m_data1, 8'h21 + beats);
        beats++;
        last_b = k;
      end
      @(negedge clk);
    end
    checkOutput("bp_beats", beats, 6);
    checkOutput("bp_no_gaps", last_b - first_b, 5);

    // Empty source: a single word.
    loadWord(8'h5A);
    reads = 0; beats = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (fifo_rd_en1) reads++;
      if (m_valid1) begin
        checkOutput("empty_data", m_data1, 8'h5A);
        beats++;
      end
      @(negedge clk);
    end
    #1;
    checkOutput("empty_rd_pulses", reads, 1);
    checkOutput("empty_beats", beats, 1);
    checkOutput("empty_rd_en_idle", fifo_rd_en1, 0);
    @(negedge clk);

    // Unexpected fifo_valid while the buffer holds two words.
    m_ready1 = 1'b0;
    loadWord(8'h31);
    loadWord(8'h32);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("err_pre_occ", occupancy1, 2);
    checkOutput("err_pre_flag", err1, 0);
    @(negedge clk);
    inj_valid = 1'b1;
    #1;
    checkOutput("err_same_cycle", err1, 0);
    @(negedge clk);
    inj_valid = 1'b0;
    #1;
    checkOutput("err_set", err1, 1);
    checkOutput("err_occ_unchanged", occupancy1, 2);
    checkOutput("err_head_unchanged", m_data1, 8'h31);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("err_sticky", err1, 1);

    // Reset mid-stream with occupancy 2: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_rd_en", fifo_rd_en1, 0);
    checkOutput("mid_reset_m_valid", m_valid1, 0);
    checkOutput("mid_reset_m_data", m_data1, 0);
    checkOutput("mid_reset_occupancy", occupancy1, 0);
    checkOutput("mid_reset_err", err1, 0);
    wr_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready1 = 1'b1;
    loadWord(8'h71);
    loadWord(8'h72);
    loadWord(8'h73);
    beats = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (m_valid1) begin
        checkOutput($sformatf("restart_data_%0d", beats), m_data1, 8'h71 + beats);
        beats++;
      end
      @(negedge clk);
    end
    checkOutput("restart_beats", beats, 3);
    checkOutput("restart_err", err1, 0);

    // Flush on dut2 with occupancy 2 and one read in flight.
    rst2_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("flush_row%0d_rd_en", i), fifo_rd_en2, vecs[i].exp_rd);
      checkOutput($sformatf("flush_row%0d_m_valid", i), m_valid2, vecs[i].exp_mv);
      checkOutput($sformatf("flush_row%0d_occ", i), occupancy2, vecs[i].exp_occ);
      checkOutput($sformatf("flush_row%0d_err", i), err2, 0);
      if (vecs[i].chk_md)
        checkOutput($sformatf("flush_row%0d_m_data", i), m_data2, vecs[i].exp_md);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
